mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameters: DATA_W, default 32, data width; ADDR_W, default 32, address width; STARVE_MAX, default 4, maximum consecutive lost DMA cycles in RUN.
REQ-002 The block SHALL have this port: clk  in  1  rising-edge clock.
REQ-003 The block SHALL have this port: rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have this port: switchStart  in  1  start switch; ends the load phase.
REQ-005 The block SHALL have these CPU ports: cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wd in DATA_W (request, write enable, address, write data).
REQ-006 The block SHALL have these CPU ports: cpu_stall out 1, cpu_rd out DATA_W, cpu_rvalid out 1 (stall, read data, read data valid).
REQ-007 The block SHALL have these DMA/loader ports: dma_req in 1, dma_we in 1, dma_addr in ADDR_W, dma_wd in DATA_W (same meanings as the CPU inputs).
REQ-008 The block SHALL have these DMA/loader ports: dma_gnt out 1, dma_rd out DATA_W, dma_rvalid out 1 (grant, read data, read data valid).
REQ-009 The block SHALL have these memory ports: mem_we out 1, mem_addr out ADDR_W, mem_wd out DATA_W, mem_rd in DATA_W; the memory is single-port with synchronous read and 1-cycle latency.

Function
REQ-010 The block SHALL hold phase register LOAD/RUN: LOAD->RUN when switchStart=1 is sampled at a clk edge; RUN is sticky until reset.
REQ-011 Grant SHALL be combinational from the current-cycle requests, phase and starve_cnt; at most one port is granted per cycle.
REQ-012 With one requester only, that requester SHALL be granted.
REQ-013 With both requesting in LOAD, DMA SHALL be granted.
REQ-014 With both requesting in RUN, CPU SHALL be granted unless starve_cnt==STARVE_MAX, in which case DMA SHALL be granted.
REQ-015 starve_cnt SHALL be a register: +1 per cycle in RUN where dma_req=1 and DMA is not granted, saturating at STARVE_MAX; cleared when DMA is granted or dma_req=0.
REQ-016 In LOAD, starve_cnt SHALL be held at 0.
REQ-017 The granted port's we/addr/wd SHALL drive mem_we/mem_addr/mem_wd that cycle.
REQ-018 With no grant: mem_we=0, mem_addr=0, mem_wd=0.
REQ-019 cpu_stall SHALL equal cpu_req AND NOT cpu_granted, combinationally.
REQ-020 dma_gnt SHALL equal DMA granted, combinationally.
REQ-021 A granted read (we=0) SHALL record rd_owner (CPU/DMA) at the clk edge; the next cycle, the owner's rvalid=1 for exactly one cycle and its rd=mem_rd.
REQ-022 A granted write SHALL set rd_owner=NONE and SHALL produce no rvalid.
REQ-023 Back-to-back reads SHALL be supported at one per cycle with no bubble; rvalid SHALL follow each granted read by exactly 1 cycle.
REQ-024 cpu_rd and dma_rd SHALL pass mem_rd through unconditionally; only rvalid qualifies them.
REQ-025 The block SHALL add no latency to writes; the memory commits a write at the edge ending the grant cycle.

Reset
REQ-026 rst_n=0 SHALL asynchronously set: phase=LOAD, starve_cnt=0, rd_owner=NONE, cpu_rvalid=0, dma_rvalid=0.
REQ-027 While rst_n=0, mem_we SHALL be 0 regardless of requests.
REQ-028 Reset mid-read SHALL discard the in-flight read; no rvalid SHALL appear after release.
REQ-029 The first edge after rst_n deasserts SHALL begin normal arbitration with phase=LOAD.

Verification
REQ-030 Load priority: LOAD, both req, dma_we=1, dma_addr=0x10, dma_wd=0xAA -> dma_gnt=1, cpu_stall=1, mem_we=1, mem_addr=0x10, mem_wd=0xAA.
REQ-031 Phase switch: switchStart pulsed 1 cycle, then 0 -> phase RUN persists; both req -> CPU granted.
REQ-032 Starvation: RUN, STARVE_MAX=4, both req continuously -> CPU granted cycles 1-4, DMA cycle 5, CPU cycle 6; pattern repeats.
REQ-033 Read latency: CPU reads addr 0x20 (mem returns 0x1234) in cycle N -> cpu_rvalid=1 and cpu_rd=0x1234 in N+1; dma_rvalid=0 throughout.
REQ-034 Back-to-back: CPU read, DMA read, CPU write on cycles N..N+2 -> cpu_rvalid at N+1, dma_rvalid at N+2, no rvalid at N+3.
REQ-035 Reset mid-op: CPU read at N, rst_n=0 during N+1 -> cpu_rvalid=0 immediately, phase=LOAD, starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU port and a DMA/loader port onto one single-port synchronous-read memory.
// Grant is combinational, read data returns one cycle later, and DMA has a bounded starvation window in RUN.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              switchStart,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wd,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rd,
  output logic              dma_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic {PH_LOAD, PH_RUN} phase_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;

  phase_e           phase_q, phase_d;
  owner_e           rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             cpu_gnt, dma_gnt_w;

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt_w = 1'b0;
    if (cpu_req && dma_req) begin
      // In LOAD the loader owns the memory; in RUN the CPU wins until DMA has waited STARVE_MAX cycles.
      if (phase_q == PH_LOAD || starve_cnt_q == CNT_MAX) begin
        dma_gnt_w = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (dma_req) begin
      dma_gnt_w = 1'b1;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end else if (dma_gnt_w) begin
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_wd   = dma_wd;
    end
    // No write may reach the memory while the block is held in reset.
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  always_comb begin
    phase_d      = phase_q;
    starve_cnt_d = '0;
    rd_owner_d   = OWN_NONE;
    if (phase_q == PH_LOAD && switchStart) begin
      phase_d = PH_RUN;
    end
    if (phase_q == PH_RUN && dma_req && !dma_gnt_w) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
    end
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt_w && !dma_we) begin
      rd_owner_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PH_LOAD;
      starve_cnt_q <= '0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      phase_q      <= phase_d;
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign dma_gnt    = dma_gnt_w;
  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign dma_rvalid = (rd_owner_q == OWN_DMA);
  assign cpu_rd     = mem_rd;
  assign dma_rd     = mem_rd;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256-word synchronous-read memory attached.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        switchStart;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wd;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rd;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wd;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rd;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic [31:0] mem_rd;
  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wd;
    mem_rd <= mem[mem_addr[7:0]];
  end

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .switchStart(switchStart),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_stall(cpu_stall), .cpu_rd(cpu_rd), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_gnt(dma_gnt), .dma_rd(dma_rd), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] ca, input logic [31:0] cw,
                       input logic dreq, input logic dwe, input logic [31:0] da, input logic [31:0] dw);
    cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wd = cw;
    dma_req = dreq; dma_we = dwe; dma_addr = da; dma_wd = dw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    switchStart = 1'b0;
    drive(1, 1, 32'h4, 32'h11, 1, 1, 32'h8, 32'h22);
    #3;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dma_rvalid: got %b want 0", dma_rvalid); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_priority();
    @(negedge clk);
    drive(1, 1, 32'h44, 32'h55, 1, 1, 32'h10, 32'hAA);
    #1;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL load_dma_gnt: got %b want 1", dma_gnt); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_cpu_stall: got %b want 1", cpu_stall); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL load_mem_we: got %b want 1", mem_we); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL load_mem_addr: got %h want 10", mem_addr); end
    checks++; if (mem_wd !== 32'hAA) begin errors++; $display("FAIL load_mem_wd: got %h want aa", mem_wd); end
    @(negedge clk);
    drive(1, 0, 32'h10, 32'h0, 0, 1, 32'h99, 32'h99);
    #1;
    checks++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL load_cpu_only: stall=%b gnt=%b want 0 0", cpu_stall, dma_gnt); end
    checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL load_cpu_only_mem: addr=%h we=%b want 10 0", mem_addr, mem_we); end
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rd !== 32'hAA) begin errors++; $display("FAIL load_readback: rvalid=%b rd=%h want 1 aa", cpu_rvalid, cpu_rd); end
    drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234);
    #1;
    checks++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL load_dma_only: gnt=%b we=%b want 1 1", dma_gnt, mem_we); end
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL load_one_rvalid: got %b want 0", cpu_rvalid); end
    drive(1, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'hBEEF);
    #1;
    checks++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1) begin errors++; $display("FAIL load_both_read: gnt=%b stall=%b want 1 1", dma_gnt, cpu_stall); end
    @(negedge clk);
    drive(0, 1, 32'h55, 32'h66, 0, 1, 32'h77, 32'h88);
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin errors++; $display("FAIL idle_mem: we=%b addr=%h wd=%h want 0 0 0", mem_we, mem_addr, mem_wd); end
    checks++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_gnt: gnt=%b stall=%b want 0 0", dma_gnt, cpu_stall); end
    checks++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid: c=%b d=%b want 0 0", cpu_rvalid, dma_rvalid); end
  endtask

  task automatic test_phase_switch();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    switchStart = 1'b1;
    @(negedge clk);
    switchStart = 1'b0;
    @(negedge clk);
    drive(1, 1, 32'h80, 32'h1, 1, 1, 32'h90, 32'h2);
    #1;
    checks++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL run_cpu_priority: gnt=%b stall=%b want 0 0", dma_gnt, cpu_stall); end
    checks++; if (mem_addr !== 32'h80) begin errors++; $display("FAIL run_mem_addr: got %h want 80", mem_addr); end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 32'h90, 32'h2);
    #1;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL run_dma_only: got %b want 1", dma_gnt); end
  endtask

  task automatic test_starvation();
    logic exp_dma;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      drive(1, 1, 32'h80, k, 1, 1, 32'h90, k);
      exp_dma = (k % 5 == 0);
      #1;
      checks++;
      if (dma_gnt !== exp_dma || cpu_stall !== exp_dma || mem_addr !== (exp_dma ? 32'h90 : 32'h80)) begin
        errors++;
        $display("FAIL starve_cycle%0d: gnt=%b stall=%b addr=%h want gnt=%b", k, dma_gnt, cpu_stall, mem_addr, exp_dma);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
    #1;
    checks++; if (cpu_stall !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h20) begin errors++; $display("FAIL b2b_cpu_read_issue: stall=%b we=%b addr=%h", cpu_stall, mem_we, mem_addr); end
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rd !== 32'h1234 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_n1: crv=%b crd=%h drv=%b want 1 1234 0", cpu_rvalid, cpu_rd, dma_rvalid); end
    drive(0, 0, 0, 0, 1, 0, 32'h30, 0);
    @(negedge clk);
    checks++; if (dma_rvalid !== 1'b1 || dma_rd !== 32'hBEEF || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_n2: drv=%b drd=%h crv=%b want 1 beef 0", dma_rvalid, dma_rd, cpu_rvalid); end
    drive(1, 1, 32'h40, 32'h77, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_n3: crv=%b drv=%b want 0 0", cpu_rvalid, dma_rvalid); end
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rd !== 32'h77) begin errors++; $display("FAIL b2b_write_commit: rv=%b rd=%h want 1 77", cpu_rvalid, cpu_rd); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", cpu_rvalid); end
    drive(1, 1, 32'h44, 32'h5, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: c=%b d=%b want 0 0", cpu_rvalid, dma_rvalid); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_mem_we: got %b want 0", mem_we); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_after: c=%b d=%b want 0 0", cpu_rvalid, dma_rvalid); end
    drive(1, 1, 32'h80, 0, 1, 1, 32'h90, 0);
    #1;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL midrst_phase_load: gnt=%b want 1", dma_gnt); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    switchStart = 1'b1;
    @(negedge clk);
    switchStart = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(1, 1, 32'h80, 0, 1, 1, 32'h90, 0);
      #1;
      checks++;
      if (dma_gnt !== (k == 5)) begin errors++; $display("FAIL midrst_starve%0d: gnt=%b want %b", k, dma_gnt, (k == 5)); end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load_priority();
    test_phase_switch();
    test_starvation();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
